mfp_ahb_uart_tx: RTL and testbench

AHB-Lite slave that carries bytes from the MIPS core out of the board on a serial line, the counterpart of the UART_RX serial-loader path. The core writes bytes into a transmit FIFO through a small register window. An 8N1 transmitter drains the FIFO at a programmable bit period. The block sits on the AHB-Lite bus beside the memory and GPIO slaves and is selected by the bus decoder through HSEL.

---
 rtl/mfp_ahb_uart_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_mfp_ahb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave feeding an 8N1 serial transmitter through a byte FIFO.
// Registers: TXDATA (push), STATUS (busy/empty/full/overflow/count), DIVISOR (HCLK cycles per bit).
//   state    | meaning
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (high); may pop the next byte on its last cycle
module mfp_ahb_uart_tx #(
    parameter int          FIFO_DEPTH = 16,
    parameter int unsigned DIV_RESET  = 434
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic          dp_valid;
    logic          dp_write;
    logic [1:0]    dp_addr;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_div;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          overflow;
    logic [15:0]   divisor;

    state_t        state, state_next;
    logic [15:0]   baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic [15:0]   div_act, div_next;
    logic          tx_next;
    logic          bit_end;
    logic          busy;

    logic          unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else if (HREADY) begin
            dp_valid <= HSEL & HTRANS[1];
            dp_write <= HWRITE;
            dp_addr  <= HADDR[3:2];
        end
    end

    assign wr_txdata = dp_valid & dp_write & (dp_addr == 2'd0);
    assign wr_status = dp_valid & dp_write & (dp_addr == 2'd1);
    assign wr_div    = dp_valid & dp_write & (dp_addr == 2'd2);

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
    assign push       = wr_txdata & (~fifo_full | pop);

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            overflow <= 1'b0;
            divisor  <= 16'(DIV_RESET);
        end else begin
            if (wr_txdata && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_status && HWDATA[3]) begin
                overflow <= 1'b0;
            end
            if (wr_div) begin
                divisor <= (HWDATA[15:0] < 16'd4) ? 16'd4 : HWDATA[15:0];
            end
        end
    end

    assign bit_end = (baud_cnt == div_act - 16'd1);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        div_next   = div_act;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    div_next   = divisor;
                    baud_next  = 16'd0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_next = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_next = 16'd0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        div_next   = divisor;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line level is registered from the next-state values so it switches
    // on the same edge as the FSM without any combinational path to the pin.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[bit_next];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            div_act   <= 16'(DIV_RESET);
            UART_TX   <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            div_act   <= div_next;
            UART_TX   <= tx_next;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                2'd1:    HRDATA = {16'd0, 8'(fifo_cnt), 4'd0, overflow, fifo_full, fifo_empty, busy};
                2'd2:    HRDATA = {16'd0, divisor};
                default: HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Randomized and directed bench for mfp_ahb_uart_tx; a frame monitor decodes UART_TX
// and compares each frame against a queue of expected (byte, bit period) pairs.
module tb_mfp_ahb_uart_tx;

    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        UART_TX;

    mfp_ahb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(434)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .UART_TX(UART_TX)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct { logic [7:0] data; int div; } frame_t;

    frame_t     exp_q[$];
    int         mon_starts[$];
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] bbuf [0:7];

    initial forever begin
        @(posedge HCLK);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void expect_frame(input logic [7:0] d, input int dv);
        frame_t f;
        f.data = d;
        f.div  = dv;
        exp_q.push_back(f);
    endfunction

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a, 2'b00};
        @(negedge HCLK);
        HWDATA = d;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a, 2'b00};
        @(negedge HCLK);
        bus_idle();
        d = HRDATA;
    endtask

    // Pipelined TXDATA writes on consecutive cycles; returns in the last data phase.
    task automatic write_burst(input int n);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            HWDATA = {24'd0, bbuf[i]};
            if (i == n - 1) bus_idle();
        end
    endtask

    task automatic wait_idle(input int limit);
        logic [31:0] st;
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            bus_read(2'd1, st);
            if (!st[0] && st[1]) done = 1'b1;
        end
        chk("idle_wait", {31'd0, done}, 32'd1);
        repeat (2) @(negedge HCLK);
        chk("frames_left", exp_q.size(), 0);
    endtask

    // Frame monitor: start at any low sample, then 10 bit periods of the expected length.
    initial begin : monitor
        frame_t     e;
        logic [7:0] b;
        bit         shape_ok;
        bit         aborted;
        int         d;
        int         bp;
        forever begin
            @(negedge HCLK);
            if (mon_en && UART_TX == 1'b0) begin
                chk("mon_expected_frame", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin e.data = 8'h00; e.div = 4; end
                d = e.div;
                mon_starts.push_back(cyc);
                shape_ok = 1'b1;
                aborted  = 1'b0;
                b        = 8'h00;
                for (int s = 0; s < 10 * d; s++) begin
                    if (s > 0) @(negedge HCLK);
                    if (!mon_en) aborted = 1'b1;
                    bp = s / d;
                    if (bp == 0) begin
                        if (UART_TX !== 1'b0) shape_ok = 1'b0;
                    end else if (bp <= 8) begin
                        if (s % d == 0) b[bp-1] = UART_TX;
                        else if (UART_TX !== b[bp-1]) shape_ok = 1'b0;
                    end else begin
                        if (UART_TX !== 1'b1) shape_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    chk("mon_byte", {24'd0, b}, {24'd0, e.data});
                    chk("mon_shape", {31'd0, shape_ok}, 32'd1);
                end
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        logic [7:0]  sb;
        int          t;
        int          n;
        int          dv;
        int          lows;
        logic        exp_tx;

        HRESETn = 1'b0;
        HADDR   = 32'd0;
        HSIZE   = 3'b010;
        HWDATA  = 32'd0;
        HREADY  = 1'b1;
        bus_idle();
        repeat (3) @(negedge HCLK);
        chk("rst_tx", {31'd0, UART_TX}, 32'd1);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        mon_en = 1'b1;

        bus_read(2'd1, rd);  chk("rst_status", rd, 32'h0000_0002);
        bus_read(2'd2, rd);  chk("rst_divisor", rd, 32'd434);
        bus_read(2'd0, rd);  chk("txdata_read", rd, 32'd0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd);  chk("reg3_read", rd, 32'd0);
        bus_write(2'd2, 32'd2);
        bus_read(2'd2, rd);  chk("div_clamp", rd, 32'd4);

        // Single byte, DIVISOR=4, with STATUS read back every cycle.
        sb = 8'h55;
        expect_frame(sb, 4);
        bus_write(2'd0, {24'd0, sb});
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
        for (int k = 1; k <= 44; k++) begin
            @(negedge HCLK);
            t = k - 2;
            if (t < 0)       exp_tx = 1'b1;
            else if (t < 4)  exp_tx = 1'b0;
            else if (t < 36) exp_tx = sb[(t - 4) / 4];
            else             exp_tx = 1'b1;
            chk($sformatf("sb_tx_k%0d", k), {31'd0, UART_TX}, {31'd0, exp_tx});
            chk($sformatf("sb_busy_k%0d", k), {31'd0, HRDATA[0]}, {31'd0, (k >= 2 && k <= 41)});
        end
        bus_idle();
        wait_idle(200);

        // Back-to-back frames must be contiguous, 40 cycles apart.
        bbuf[0] = 8'hA3; bbuf[1] = 8'h0F; bbuf[2] = 8'hFF;
        for (int i = 0; i < 3; i++) expect_frame(bbuf[i], 4);
        mon_starts.delete();
        write_burst(3);
        wait_idle(400);
        chk("b2b_frames", mon_starts.size(), 3);
        if (mon_starts.size() == 3) begin
            chk("b2b_gap01", mon_starts[1] - mon_starts[0], 40);
            chk("b2b_gap12", mon_starts[2] - mon_starts[1], 40);
        end

        // DIVISOR change mid-frame applies only from the next pop.
        bbuf[0] = 8'h3C; bbuf[1] = 8'hC5;
        expect_frame(bbuf[0], 4);
        expect_frame(bbuf[1], 8);
        mon_starts.delete();
        write_burst(2);
        repeat (10) @(negedge HCLK);
        bus_write(2'd2, 32'd8);
        bus_read(2'd2, rd);  chk("div_readback", rd, 32'd8);
        wait_idle(400);
        chk("div_frames", mon_starts.size(), 2);
        if (mon_starts.size() == 2) chk("div_gap", mon_starts[1] - mon_starts[0], 40);

        // Random bursts from idle: every byte of a burst up to DEPTH+1 is accepted.
        for (int r = 0; r < 6; r++) begin
            dv = $urandom_range(7, 4);
            n  = $urandom_range(DEPTH + 1, 1);
            bus_write(2'd2, dv);
            for (int i = 0; i < n; i++) begin
                bbuf[i] = 8'($urandom);
                expect_frame(bbuf[i], dv);
            end
            write_burst(n);
            bus_read(2'd1, rd);
            chk($sformatf("rnd%0d_status", r), rd,
                {16'd0, 8'(n - 1), 4'd0, 1'b0, (n - 1 == DEPTH), (n == 1), 1'b1});
            wait_idle(50 * dv * n + 100);
        end

        // Overflow: six writes into a depth-4 FIFO with a slow first frame.
        bus_write(2'd2, 32'd1000);
        for (int i = 0; i < 6; i++) bbuf[i] = 8'(8'h10 + i * 8'h11);
        expect_frame(bbuf[0], 1000);
        for (int i = 1; i < 5; i++) expect_frame(bbuf[i], 4);
        write_burst(6);
        bus_read(2'd1, rd);  chk("ovf_status", rd, 32'h0000_040D);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd);  chk("ovf_cleared", rd, 32'h0000_0405);
        bus_write(2'd2, 32'd4);
        wait_idle(8000);

        // Reset in the middle of a data bit with three bytes still queued.
        mon_en = 1'b0;
        bus_write(2'd2, 32'd8);
        bbuf[0] = 8'h00; bbuf[1] = 8'h81; bbuf[2] = 8'h42; bbuf[3] = 8'h18;
        write_burst(4);
        repeat (15) @(negedge HCLK);
        chk("rst_pre_tx", {31'd0, UART_TX}, 32'd0);
        HRESETn = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4;
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus_idle();
        chk("rst_mid_tx", {31'd0, UART_TX}, 32'd1);
        chk("rst_mid_hrdata", HRDATA, 32'd0);
        bus_read(2'd1, rd);  chk("rst_mid_status", rd, 32'h0000_0002);
        bus_read(2'd2, rd);  chk("rst_mid_divisor", rd, 32'd434);
        mon_en = 1'b1;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge HCLK);
            if (UART_TX !== 1'b1) lows++;
        end
        chk("rst_quiet", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
